// File: rtl/regfile_mp.sv
// Multi-port register file with byte-enabled writes, optional write-to-read bypass and a
// per-register busy scoreboard for RAW hazard detection. Register 0 is hard-wired to zero.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 4,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD*ADDR_W-1:0]     raddr,
    output logic [NUM_RD*DATA_W-1:0]     rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic [NUM_WR*DATA_W/8-1:0]   we,
    input  logic [NUM_WR*ADDR_W-1:0]     waddr,
    input  logic [NUM_WR*DATA_W-1:0]     wdata,
    input  logic [NUM_WR-1:0]            wclr,
    input  logic [NUM_WR-1:0]            set_valid,
    input  logic [NUM_WR*ADDR_W-1:0]     set_addr
);

    localparam int unsigned NUM_REGS  = 2**ADDR_W;
    localparam int unsigned NUM_BYTES = DATA_W/8;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_next;
    logic [NUM_REGS-1:0]             busy;
    logic [NUM_REGS-1:0]             busy_next;

    // Per-byte merge of all write ports; later ports overwrite earlier ones (younger wins).
    always_comb begin : write_merge
        regs_next    = regs;
        regs_next[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (we[j*NUM_BYTES + b] && (waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                        regs_next[r][b*8 +: 8] = wdata[j*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

    // Clears are applied before sets so a newly issued producer keeps the register busy.
    always_comb begin : busy_merge
        busy_next = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wclr[j] && (waddr[j*ADDR_W +: ADDR_W] != '0)) begin
                busy_next[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (set_valid[j] && (set_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                busy_next[set_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin : state_reg
        if (reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            regs <= regs_next;
            busy <= busy_next;
        end
    end

    // Read ports: bypass selects the exact next-state value; reset forces zero on all ports.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] src;

        assign ra = raddr[i*ADDR_W +: ADDR_W];

        if (BYPASS != 0) begin : g_byp
            assign src = regs_next[ra];
        end else begin : g_nobyp
            assign src = regs[ra];
        end

        assign rdata[i*DATA_W +: DATA_W] = (reset || (ra == '0)) ? '0 : src;
        assign rbusy[i]                  = (ra != '0) && busy[ra];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance share all inputs.
module tb_regfile_mp;

    logic         clk;
    logic         reset;
    logic [19:0]  raddr;
    logic [127:0] rdata_b;
    logic [127:0] rdata_n;
    logic [3:0]   rbusy_b;
    logic [3:0]   rbusy_n;
    logic [7:0]   we;
    logic [9:0]   waddr;
    logic [63:0]  wdata;
    logic [1:0]   wclr;
    logic [1:0]   set_valid;
    logic [9:0]   set_addr;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .wclr(wclr),
        .set_valid(set_valid), .set_addr(set_addr)
    );

    regfile_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .we(we), .waddr(waddr), .wdata(wdata), .wclr(wclr),
        .set_valid(set_valid), .set_addr(set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rb(input int p);
        return rdata_b[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rn(input int p);
        return rdata_n[p*32 +: 32];
    endfunction

    task automatic idle();
        we = '0; waddr = '0; wdata = '0; wclr = '0; set_valid = '0; set_addr = '0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        we[p*4 +: 4]     = be;
        waddr[p*5 +: 5]  = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        raddr[p*5 +: 5] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        raddr = {4{5'd5}};
        #3;
        checks++;
        if (rdata_b !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_b); end
        checks++;
        if (rbusy_b !== 4'b0) begin errors++; $display("FAIL reset_rbusy got %b want 0", rbusy_b); end
        // a write pending across an edge while reset is high must be dropped
        wr(0, 5'd6, 4'hF, 32'h0000_0001);
        tick();
        reset = 1'b0;
        idle();
        tick();
        rd(0, 5'd6);
        #1;
        checks++;
        if (rn(0) !== 32'h0) begin errors++; $display("FAIL reset_drop_write got %h want 0", rn(0)); end
        // load r5 and mark it busy, then reset asynchronously between edges
        wr(0, 5'd5, 4'hF, 32'hDEAD_BEEF);
        set_valid[0] = 1'b1;
        set_addr[4:0] = 5'd5;
        tick();
        idle();
        rd(0, 5'd5);
        #1;
        checks++;
        if (rn(0) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL r5_loaded got %h want deadbeef", rn(0)); end
        checks++;
        if (rbusy_n[0] !== 1'b1) begin errors++; $display("FAIL r5_busy got %b want 1", rbusy_n[0]); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rn(0) !== 32'h0 || rb(0) !== 32'h0) begin
            errors++; $display("FAIL async_reset_rdata got %h/%h want 0", rn(0), rb(0));
        end
        checks++;
        if (rbusy_n[0] !== 1'b0) begin errors++; $display("FAIL async_reset_rbusy got %b want 0", rbusy_n[0]); end
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_byte_en();
        idle();
        wr(0, 5'd3, 4'hF, 32'h1122_3344);
        tick();
        idle();
        wr(0, 5'd3, 4'b0101, 32'hAABB_CCDD);
        rd(0, 5'd3);
        #1;
        checks++;
        if (rb(0) !== 32'h11BB_33DD) begin errors++; $display("FAIL byte_en_bypass got %h want 11bb33dd", rb(0)); end
        checks++;
        if (rn(0) !== 32'h1122_3344) begin errors++; $display("FAIL byte_en_old got %h want 11223344", rn(0)); end
        tick();
        idle();
        #1;
        checks++;
        if (rn(0) !== 32'h11BB_33DD) begin errors++; $display("FAIL byte_en_stored got %h want 11bb33dd", rn(0)); end
    endtask

    task automatic test_collision();
        idle();
        wr(0, 5'd7, 4'hF, 32'h0000_0001);
        wr(1, 5'd7, 4'b0011, 32'h0000_FFFF);
        rd(1, 5'd7);
        #1;
        checks++;
        if (rb(1) !== 32'h0000_FFFF) begin errors++; $display("FAIL collide_lo_bypass got %h want 0000ffff", rb(1)); end
        tick();
        idle();
        #1;
        checks++;
        if (rn(1) !== 32'h0000_FFFF) begin errors++; $display("FAIL collide_lo got %h want 0000ffff", rn(1)); end
        wr(0, 5'd7, 4'hF, 32'h0000_0001);
        wr(1, 5'd7, 4'b1100, 32'hABCD_0000);
        #1;
        checks++;
        if (rb(1) !== 32'hABCD_0001) begin errors++; $display("FAIL collide_hi_bypass got %h want abcd0001", rb(1)); end
        tick();
        idle();
        #1;
        checks++;
        if (rn(1) !== 32'hABCD_0001) begin errors++; $display("FAIL collide_hi got %h want abcd0001", rn(1)); end
    endtask

    task automatic test_bypass();
        idle();
        wr(1, 5'd9, 4'hF, 32'hCAFE_F00D);
        tick();
        idle();
        wr(0, 5'd9, 4'hF, 32'h1234_5678);
        rd(2, 5'd9);
        #1;
        checks++;
        if (rb(2) !== 32'h1234_5678) begin errors++; $display("FAIL bypass_same got %h want 12345678", rb(2)); end
        checks++;
        if (rn(2) !== 32'hCAFE_F00D) begin errors++; $display("FAIL nobypass_same got %h want cafef00d", rn(2)); end
        tick();
        idle();
        #1;
        checks++;
        if (rn(2) !== 32'h1234_5678) begin errors++; $display("FAIL nobypass_next got %h want 12345678", rn(2)); end
    endtask

    task automatic test_scoreboard();
        idle();
        rd(3, 5'd4);
        set_valid[1] = 1'b1;
        set_addr[9:5] = 5'd4;
        #1;
        checks++;
        if (rbusy_b[3] !== 1'b0) begin errors++; $display("FAIL busy_no_bypass got %b want 0", rbusy_b[3]); end
        tick();
        idle();
        #1;
        checks++;
        if (rbusy_b[3] !== 1'b1) begin errors++; $display("FAIL busy_set got %b want 1", rbusy_b[3]); end
        set_valid[0] = 1'b1;
        set_addr[4:0] = 5'd4;
        wclr[1] = 1'b1;
        waddr[9:5] = 5'd4;
        tick();
        idle();
        #1;
        checks++;
        if (rbusy_b[3] !== 1'b1) begin errors++; $display("FAIL busy_set_wins got %b want 1", rbusy_b[3]); end
        wclr[0] = 1'b1;
        waddr[4:0] = 5'd4;
        #1;
        checks++;
        if (rbusy_b[3] !== 1'b1) begin errors++; $display("FAIL busy_clr_pending got %b want 1", rbusy_b[3]); end
        tick();
        idle();
        #1;
        checks++;
        if (rbusy_b[3] !== 1'b0) begin errors++; $display("FAIL busy_clr got %b want 0", rbusy_b[3]); end
        set_valid = 2'b11;
        set_addr = '0;
        tick();
        idle();
        raddr = '0;
        #1;
        checks++;
        if (rbusy_b !== 4'b0 || rbusy_n !== 4'b0) begin
            errors++; $display("FAIL busy_r0 got %b/%b want 0", rbusy_b, rbusy_n);
        end
    endtask

    task automatic test_r0();
        idle();
        raddr = '0;
        wr(0, 5'd0, 4'hF, 32'hFFFF_FFFF);
        wr(1, 5'd0, 4'hF, 32'hFFFF_FFFF);
        #1;
        checks++;
        if (rdata_b !== '0) begin errors++; $display("FAIL r0_bypass got %h want 0", rdata_b); end
        tick();
        idle();
        #1;
        checks++;
        if (rdata_n !== '0 || rdata_b !== '0) begin
            errors++; $display("FAIL r0_stored got %h/%h want 0", rdata_n, rdata_b);
        end
        // earlier registers must be untouched by the r0 writes
        rd(0, 5'd3);
        rd(1, 5'd7);
        #1;
        checks++;
        if (rn(0) !== 32'h11BB_33DD || rn(1) !== 32'hABCD_0001) begin
            errors++; $display("FAIL r0_no_alias got %h/%h want 11bb33dd/abcd0001", rn(0), rn(1));
        end
    endtask

    initial begin
        raddr = '0;
        test_reset();
        test_byte_en();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_r0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
